// File: rtl/led_bar_feeder.sv
// Front end for the LED bar. It takes sensor samples over valid/ready, applies an EMA
// filter, scales and clamps the result into the bar's range, and produces a debounced blink.
module led_bar_feeder #(
  parameter int IN_BITS   = 12,
  parameter int K         = 2,
  parameter int VAL_BITS  = 3,
  parameter int VAL_L     = 0,
  parameter int VAL_U     = 7,
  parameter int WARN_TH   = 3584,
  parameter int WARN_HYST = 256,
  parameter int WARN_CNT  = 4,
  parameter int HOLD_N    = 8,
  parameter int CNT_BITS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [IN_BITS-1:0]  sample,
  output logic                sample_ready,
  output logic [VAL_BITS-1:0] value,
  output logic                blink,
  output logic                value_valid
);
  localparam int AW = IN_BITS + K;
  localparam logic [IN_BITS-1:0]  TH  = IN_BITS'(WARN_TH);
  localparam logic [IN_BITS-1:0]  REL = IN_BITS'(WARN_TH - WARN_HYST);
  localparam logic [VAL_BITS-1:0] VL  = VAL_BITS'(VAL_L);
  localparam logic [VAL_BITS-1:0] VU  = VAL_BITS'(VAL_U);
  localparam logic [CNT_BITS-1:0] WC  = CNT_BITS'(WARN_CNT);
  localparam logic [CNT_BITS-1:0] HN  = CNT_BITS'(HOLD_N);

  typedef enum logic [1:0] {C_IDLE, C_FILT, C_OUT} ctrl_e;
  typedef enum logic [1:0] {W_NORMAL, W_ARM, W_WARN, W_HOLD} warn_e;

  ctrl_e               ctrl_q, ctrl_d;
  warn_e               warn_q, warn_d;
  logic [IN_BITS-1:0]  samp_q, samp_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic                primed_q, primed_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [VAL_BITS-1:0] value_q, value_d;
  logic                blink_q, blink_d, vv_q, vv_d;

  logic [IN_BITS-1:0]  filt;
  logic [VAL_BITS-1:0] scaled;
  logic                over;

  // filt is derived from the registered acc, so in OUT it already reflects this sample.
  assign filt   = acc_q[AW-1:K];
  assign scaled = filt[IN_BITS-1 -: VAL_BITS];
  assign over   = (filt >= TH);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= C_IDLE;
      warn_q   <= W_NORMAL;
      samp_q   <= '0;
      acc_q    <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      value_q  <= VL;
      blink_q  <= 1'b0;
      vv_q     <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      warn_q   <= warn_d;
      samp_q   <= samp_d;
      acc_q    <= acc_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      value_q  <= value_d;
      blink_q  <= blink_d;
      vv_q     <= vv_d;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    warn_d   = warn_q;
    samp_d   = samp_q;
    acc_d    = acc_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    value_d  = value_q;
    blink_d  = blink_q;
    vv_d     = 1'b0;
    case (ctrl_q)
      C_IDLE: if (sample_valid) begin
        samp_d = sample;
        ctrl_d = C_FILT;
      end
      C_FILT: begin
        // The first sample after reset seeds the filter so there is no slow ramp up from zero.
        if (!primed_q) acc_d = AW'(samp_q) << K;
        else           acc_d = acc_q - (acc_q >> K) + AW'(samp_q);
        primed_d = 1'b1;
        ctrl_d   = C_OUT;
      end
      C_OUT: begin
        if (scaled < VL)      value_d = VL;
        else if (scaled > VU) value_d = VU;
        else                  value_d = scaled;
        vv_d = 1'b1;
        case (warn_q)
          W_NORMAL: if (over) begin
            cnt_d  = CNT_BITS'(1);
            warn_d = (WARN_CNT == 1) ? W_WARN : W_ARM;
          end
          W_ARM: if (over) begin
            cnt_d = cnt_q + CNT_BITS'(1);
            if (cnt_q + CNT_BITS'(1) == WC) warn_d = W_WARN;
          end else begin
            cnt_d  = '0;
            warn_d = W_NORMAL;
          end
          W_WARN: if (filt < REL) begin
            hcnt_d = '0;
            warn_d = W_HOLD;
          end
          W_HOLD: if (over) begin
            warn_d = W_WARN;
          end else begin
            hcnt_d = hcnt_q + CNT_BITS'(1);
            if (hcnt_q + CNT_BITS'(1) == HN) warn_d = W_NORMAL;
          end
          default: warn_d = W_NORMAL;
        endcase
        blink_d = (warn_d == W_WARN) || (warn_d == W_HOLD);
        ctrl_d  = C_IDLE;
      end
      default: ctrl_d = C_IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (ctrl_q == C_IDLE) && !reset;
    value        = value_q;
    blink        = blink_q;
    value_valid  = vv_q;
  end
endmodule

// File: tb/tb_led_bar_feeder.sv
// Randomized bench for led_bar_feeder. A behavioural EMA and warning model predicts
// value and blink for every accepted sample. A second instance checks the clamp with VAL_U=5.
module tb_led_bar_feeder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_ready, blink, value_valid;
  logic [2:0]  value;
  logic        ready_c, blink_c, vv_c;
  logic [2:0]  value_c;

  led_bar_feeder dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .sample_ready(sample_ready), .value(value), .blink(blink), .value_valid(value_valid));

  led_bar_feeder #(.VAL_U(5)) dut_c (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .sample_ready(ready_c), .value(value_c), .blink(blink_c), .value_valid(vv_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, last_acc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a plain arithmetic EMA plus streak and hold bookkeeping.
  int  m_acc, m_streak, m_held;
  bit  m_primed, m_warning, m_holding;
  int  exp_v, exp_vc, exp_b;

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_primed = 0; m_warning = 0; m_holding = 0;
    m_streak = 0; m_held = 0;
  endtask

  task automatic model_step(input int s);
    int f;
    if (!m_primed) m_acc = s * 4;
    else           m_acc = m_acc - m_acc / 4 + s;
    m_primed = 1;
    f = m_acc / 4;
    exp_v  = clampi(f / 512, 0, 7);
    exp_vc = clampi(f / 512, 0, 5);
    if (!m_warning) begin
      m_streak = (f >= 3584) ? m_streak + 1 : 0;
      if (m_streak >= 4) begin m_warning = 1; m_holding = 0; m_streak = 0; end
    end else if (m_holding) begin
      if (f >= 3584) m_holding = 0;
      else begin
        m_held++;
        if (m_held == 8) begin m_warning = 0; m_holding = 0; end
      end
    end else if (f < 3584 - 256) begin
      m_holding = 1; m_held = 0;
    end
    exp_b = m_warning;
  endtask

  // The task is entered at a negedge and returns at the negedge where value_valid is expected.
  // sample_valid stays high through FILT and OUT with the same sample, so a duplicate
  // capture would show up as a spacing or latency error.
  task automatic send(input int s, input bit b2b);
    int w;
    w = 0;
    sample_valid = 1'b1;
    sample = s[11:0];
    while (!sample_ready && w < 20) begin @(negedge clk); w++; end
    if (!sample_ready) begin
      chk("accept_timeout", 0, 1);
      sample_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (b2b) chk("accept_spacing", cyc - last_acc, 3);
    last_acc = cyc;
    chk("ready_filt", int'(sample_ready), 0);
    chk("vv_filt", int'(value_valid), 0);
    @(negedge clk);
    chk("ready_out", int'(sample_ready), 0);
    chk("vv_out", int'(value_valid), 0);
    @(negedge clk);
    model_step(s);
    chk("vv", int'(value_valid), 1);
    chk("value", int'(value), exp_v);
    chk("blink", int'(blink), exp_b);
    chk("value_clamp5", int'(value_c), exp_vc);
    chk("ready_back", int'(sample_ready), 1);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("vv_idle", int'(value_valid), 0);
    end
  endtask

  task automatic check_reset_state(input string tag, input int rdy);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_blink"}, int'(blink), 0);
    chk({tag, "_vv"}, int'(value_valid), 0);
    chk({tag, "_ready"}, int'(sample_ready), rdy);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("in_reset", 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("post_reset", 1);
  endtask

  task automatic step_seq();
    send(0, 0);
    for (int i = 0; i < 11; i++) send(4095, 1);
  endtask

  initial begin
    model_reset();
    do_reset();

    send(2048, 0);
    idle(2);

    do_reset();
    step_seq();
    for (int i = 0; i < 9; i++) send(0, 1);
    idle(1);

    // Re-enter WARN from HOLD: one 0 sample, then 4095s until the filtered level recovers.
    do_reset();
    step_seq();
    send(0, 1);
    for (int i = 0; i < 6; i++) send(4095, 1);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      int s;
      int g;
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3000, 4095)) : int'($urandom_range(0, 4095));
      g = int'($urandom_range(0, 3));
      idle(g);
      send(s, 0);
    end

    // Reset arriving while the block is in FILT.
    send(4095, 0);
    sample_valid = 1'b1;
    sample = 12'd3000;
    begin
      int w;
      w = 0;
      while (!sample_ready && w < 20) begin @(negedge clk); w++; end
      chk("abort_accept", int'(sample_ready), 1);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort_rst", 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("abort_post", 1);
    idle(2);
    send(1024, 0);
    chk("reprime_value", int'(value), 2);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/led_bar_feeder.md
Name: led_bar_feeder

Overview:
- Upstream stage of the LED bar display.
- Accepts raw sensor samples (e.g. ADC boost/AFR readings) over a valid/ready handshake and smooths them with an exponential moving average.
- Scales and clamps the smoothed value into the bar's value range, and drives the bar's value and blink inputs.
- Blink is a debounced over-threshold warning with hysteresis and minimum hold.

Parameters:
IN_BITS, 12, width of raw sample
K, 2, EMA shift; alpha = 1/2^K
VAL_BITS, 3, width of output value (must be <= IN_BITS)
VAL_L, 0, lower clamp of output value
VAL_U, 7, upper clamp of output value
WARN_TH, 3584, filtered level at/above which a sample counts as over-threshold
WARN_HYST, 256, warning releases when filtered level < WARN_TH-WARN_HYST
WARN_CNT, 4, consecutive over-threshold samples needed to enter warning (>=1)
HOLD_N, 8, samples blink is held after release before returning to normal (>=1)
CNT_BITS, 4, width of arm/hold counters

Ports:
clk  in  1  global clock
reset  in  1  synchronous active-high reset
sample_valid  in  1  upstream sample present
sample  in  IN_BITS  raw sample, unsigned
sample_ready  out  1  block can accept a sample this cycle
value  out  VAL_BITS  smoothed, scaled, clamped value to led_bar
blink  out  1  warning blink enable to led_bar
value_valid  out  1  one-cycle pulse when value/blink update

Behaviour:
- One clock domain, clk. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: value=VAL_L, blink=0, value_valid=0, sample_ready=0 while reset is asserted, acc=0, primed=0, control FSM in IDLE, warn FSM in NORMAL, counters 0.
- Control FSM:
  - IDLE: sample_ready=1. sample_valid&&sample_ready captures sample, then -> FILT.
  - FILT: sample_ready=0. Accumulator update, then -> OUT.
  - OUT: sample_ready=0. value/blink registers update, value_valid=1 for this cycle only, then -> IDLE.
- Latency: value, blink and value_valid change 2 clocks after the accept edge. Throughput: at most 1 sample per 3 clocks.
- Samples held with sample_valid while sample_ready=0 are neither lost nor double-counted.
- Filter (acc width IN_BITS+K, cannot overflow):
  - If !primed: acc=sample<<K and primed=1.
  - Else: acc = acc - (acc>>K) + sample.
  - filt = acc>>K, taken from the updated acc.
- Scale: s = filt>>(IN_BITS-VAL_BITS). value = VAL_L if s<VAL_L, VAL_U if s>VAL_U, else s.
- Warn FSM: evaluated once per sample in OUT, using the updated filt.
  - NORMAL: filt>=WARN_TH sets cnt=1; -> WARN if WARN_CNT==1, else -> ARM.
  - ARM: filt>=WARN_TH increments cnt; on reaching WARN_CNT -> WARN. filt<WARN_TH -> NORMAL, cnt=0.
  - WARN: filt<WARN_TH-WARN_HYST -> HOLD, hcnt=0. Otherwise stays in WARN.
  - HOLD: filt>=WARN_TH -> WARN immediately, with no re-arm. Otherwise hcnt increments; on reaching HOLD_N -> NORMAL.
- blink = 1 in WARN or HOLD, registered; it updates in the same cycle as value.
- Reset mid-operation, in any state: the capture in progress is discarded, no value_valid is issued, and primed clears so the next sample re-primes.

Test Plan:
- Reset then idle -> value=0, blink=0, value_valid=0, sample_ready=1 on the first cycle after reset deasserts.
- Single sample 2048 after reset -> primed: acc=8192, filt=2048; value=4 with a one-cycle value_valid exactly 2 clocks after accept.
- Step response:
  - Stimulus: sample 0, then eleven samples of 4095.
  - Expected filt sequence: 1023, 1791, 2367, 2799, 3123, 3366, 3549, 3685, 3788, 3864, 3922.
  - blink rises with the 12th sample's value_valid, value=7.
- Release and hold, continuing from the step:
  - Feed 0: filt=2942 -> HOLD, blink stays 1.
  - Eight further 0 samples: blink drops on the 8th.
  - Repeat the sequence but insert 4095 during HOLD once filt>=3584 -> back to WARN, blink never drops.
- Handshake: sample_valid held high with a new sample each accept -> accepts spaced exactly 3 clocks apart, sample_ready low 2 clocks after each. Random valid gaps -> every offered sample produces exactly one value_valid.
- Clamp and reset:
  - Clamp: with VAL_U=5, sample 4095 -> value=5.
  - Reset: assert reset during FILT -> no value_valid, outputs reset. The next sample of 1024 re-primes, giving value=2.
